bullet_ctrl: RTL and testbench

BULLET_CTRL -- requirements
Module: bullet_ctrl

---
 rtl/bullet_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_bullet_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_ctrl.sv
// -----------------------------------------------------------------------------
// bullet_ctrl
//   Per-frame bullet manager. Holds NUM_BULLETS bullet slots. On each video
//   frame tick it spawns any pending shot, advances every live bullet by SPEED
//   pixels and then streams the live bullets, in ascending slot order, to the
//   SRAM frame writer over a valid/ready handshake.
//
// Parameters
//   NUM_BULLETS  number of bullet slots (1..8)
//   SPEED        pixels moved per frame (1..64)
//
// Ports
//   i_clk         sole clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_frame_tick  one-cycle pulse per video frame
//   i_fire        fire request level (rising edge = one shot)
//   i_fire_dir    shot direction, 0 = left, 1 = right
//   i_player_x    player X used for a spawned shot
//   i_squat       player squatting (selects spawn Y)
//   o_bul_valid   record valid
//   o_bul_x       record X
//   o_bul_y       record Y
//   i_bul_ready   frame writer accepts the record
//   o_frame_done  one-cycle pulse after the last record of a frame
//   o_fire_drop   one-cycle pulse: pending shot discarded, all slots busy
//   o_overrun     one-cycle pulse: frame tick arrived while still busy
//
// Build option
//   BULLET_WRAP_EN  when defined, bullets leaving the map wrap horizontally
//                   instead of being removed.
//
// State table
//   S_IDLE   | waiting for a frame tick; pending shot spawns on the tick
//   S_UPDATE | one slot moved per cycle, index 0..NUM_BULLETS-1
//   S_STREAM | live slots presented to the frame writer
//   S_DONE   | o_frame_done high for one cycle
// -----------------------------------------------------------------------------

package SramPkg;
  localparam int MAP_X          = 1023;
  localparam int MAP_Y          = 767;
  localparam int PLAYER_Y       = 384;
  localparam int SQUAT_PLAYER_Y = 512;
endpackage

module bullet_ctrl #(
  parameter int NUM_BULLETS = 4,
  parameter int SPEED       = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_tick,
  input  logic       i_fire,
  input  logic       i_fire_dir,
  input  logic [9:0] i_player_x,
  input  logic       i_squat,
  output logic       o_bul_valid,
  output logic [9:0] o_bul_x,
  output logic [8:0] o_bul_y,
  input  logic       i_bul_ready,
  output logic       o_frame_done,
  output logic       o_fire_drop,
  output logic       o_overrun
);

  // Index/pointer width must also hold NUM_BULLETS (one past the last slot).
  localparam int IW = $clog2(NUM_BULLETS + 1);

  localparam logic [10:0] C_SPEED   = 11'(SPEED);
  localparam logic [9:0]  C_SPEED10 = 10'(SPEED);
  localparam logic [10:0] C_MAP_X   = 11'(SramPkg::MAP_X);
`ifdef BULLET_WRAP_EN
  localparam logic [10:0] C_WRAP    = 11'd1024;
`endif
  // The record Y field is 9 bits wide, so the squat spawn height (512) is
  // carried as its low 9 bits; the frame writer adds the missing MSB.
  localparam logic [8:0]  C_Y_STAND = 9'(SramPkg::PLAYER_Y);
  localparam logic [8:0]  C_Y_SQUAT = 9'(SramPkg::SQUAT_PLAYER_Y);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt_state;

  logic [NUM_BULLETS-1:0] r_act;
  logic [NUM_BULLETS-1:0] r_dir;
  logic [NUM_BULLETS-1:0] r_skip;
  logic [9:0]             r_x [NUM_BULLETS];
  logic [8:0]             r_y [NUM_BULLETS];

  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_ptr;

  logic       r_fire_d;
  logic       r_pending;
  logic       r_fire_drop;
  logic       r_overrun;
  logic       r_valid;
  logic [9:0] r_out_x;
  logic [8:0] r_out_y;

  logic          w_fire_rise;
  logic          w_take_fire;
  logic          w_can_load;
  logic          w_free_found;
  logic [IW-1:0] w_free_idx;
  logic          w_act_found;
  logic [IW-1:0] w_act_idx;
  logic [9:0]    w_act_x;
  logic [8:0]    w_act_y;
  logic          w_cur_act;
  logic          w_cur_dir;
  logic [9:0]    w_cur_x;
  logic [10:0]   w_sum;
  logic [9:0]    w_diff;
  logic          w_new_act;
  logic [9:0]    w_new_x;

  assign w_fire_rise = i_fire & ~r_fire_d;
  assign w_take_fire = (r_state == S_IDLE) & i_frame_tick & r_pending;
  // Output register may be reloaded when empty or being accepted this cycle.
  assign w_can_load  = ~r_valid | i_bul_ready;

  // Lowest-index free slot (scan downward so the lowest match wins).
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!r_act[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
  end

  // Lowest-index live slot at or above the stream pointer.
  always_comb begin
    w_act_found = 1'b0;
    w_act_idx   = '0;
    w_act_x     = '0;
    w_act_y     = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (r_act[i] && (IW'(i) >= r_ptr)) begin
        w_act_found = 1'b1;
        w_act_idx   = IW'(i);
        w_act_x     = r_x[i];
        w_act_y     = r_y[i];
      end
    end
  end

  // Slot currently visited by UPDATE and its moved position.
  always_comb begin
    w_cur_act = 1'b0;
    w_cur_dir = 1'b0;
    w_cur_x   = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (r_idx == IW'(i)) begin
        w_cur_act = r_act[i];
        w_cur_dir = r_dir[i];
        w_cur_x   = r_x[i];
      end
    end
  end

  assign w_sum  = {1'b0, w_cur_x} + C_SPEED;
  assign w_diff = w_cur_x - C_SPEED10;

  always_comb begin
    w_new_act = w_cur_act;
    w_new_x   = w_cur_x;
    if (w_cur_dir) begin
      if (w_sum > C_MAP_X) begin
`ifdef BULLET_WRAP_EN
        w_new_x = 10'(w_sum - C_WRAP);
`else
        w_new_act = 1'b0;
`endif
      end else begin
        w_new_x = w_sum[9:0];
      end
    end else begin
      if ({1'b0, w_cur_x} < C_SPEED) begin
`ifdef BULLET_WRAP_EN
        w_new_x = 10'({1'b0, w_cur_x} + C_WRAP - C_SPEED);
`else
        w_new_act = 1'b0;
`endif
      end else begin
        w_new_x = w_diff;
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE:   if (i_frame_tick) w_nxt_state = S_UPDATE;
      S_UPDATE: if (r_idx == IW'(NUM_BULLETS - 1)) w_nxt_state = S_STREAM;
      S_STREAM: if (w_can_load && !w_act_found) w_nxt_state = S_DONE;
      S_DONE:   w_nxt_state = S_IDLE;
      default:  w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act       <= '0;
      r_dir       <= '0;
      r_skip      <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
      r_idx       <= '0;
      r_ptr       <= '0;
      r_fire_d    <= 1'b0;
      r_pending   <= 1'b0;
      r_fire_drop <= 1'b0;
      r_overrun   <= 1'b0;
      r_valid     <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      r_fire_d    <= i_fire;
      // A new edge on the spawn cycle re-arms the flag for the next frame.
      r_pending   <= w_fire_rise | (r_pending & ~w_take_fire);
      r_fire_drop <= w_take_fire & ~w_free_found;
      r_overrun   <= i_frame_tick & (r_state != S_IDLE);

      case (r_state)
        S_IDLE: begin
          r_idx   <= '0;
          r_ptr   <= '0;
          r_valid <= 1'b0;
          if (w_take_fire && w_free_found) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
              if (w_free_idx == IW'(i)) begin
                r_act[i]  <= 1'b1;
                r_skip[i] <= 1'b1;  // freshly spawned: not moved this frame
                r_dir[i]  <= i_fire_dir;
                r_x[i]    <= i_player_x;
                r_y[i]    <= i_squat ? C_Y_SQUAT : C_Y_STAND;
              end
            end
          end
        end

        S_UPDATE: begin
          r_idx <= r_idx + IW'(1);
          for (int i = 0; i < NUM_BULLETS; i++) begin
            if (r_idx == IW'(i)) begin
              if (r_skip[i]) begin
                r_skip[i] <= 1'b0;
              end else if (r_act[i]) begin
                r_act[i] <= w_new_act;
                r_x[i]   <= w_new_x;
              end
            end
          end
        end

        S_STREAM: begin
          if (w_can_load) begin
            if (w_act_found) begin
              r_valid <= 1'b1;
              r_out_x <= w_act_x;
              r_out_y <= w_act_y;
              r_ptr   <= w_act_idx + IW'(1);
            end else begin
              r_valid <= 1'b0;
            end
          end
        end

        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_bul_valid  = r_valid;
  assign o_bul_x      = r_out_x;
  assign o_bul_y      = r_out_y;
  assign o_frame_done = (r_state == S_DONE);
  assign o_fire_drop  = r_fire_drop;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_bullet_ctrl.sv
module tb_bullet_ctrl;

  localparam int NB   = 4;
  localparam int SPD  = 8;
  localparam int YST  = 384;
  localparam int YSQ  = 0;   // 512 carried in a 9-bit field
`ifdef BULLET_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       i_frame_tick;
  logic       i_fire;
  logic       i_fire_dir;
  logic [9:0] i_player_x;
  logic       i_squat;
  logic       o_bul_valid;
  logic [9:0] o_bul_x;
  logic [8:0] o_bul_y;
  logic       i_bul_ready;
  logic       o_frame_done;
  logic       o_fire_drop;
  logic       o_overrun;

  bullet_ctrl #(.NUM_BULLETS(NB), .SPEED(SPD)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_tick (i_frame_tick),
    .i_fire       (i_fire),
    .i_fire_dir   (i_fire_dir),
    .i_player_x   (i_player_x),
    .i_squat      (i_squat),
    .o_bul_valid  (o_bul_valid),
    .o_bul_x      (o_bul_x),
    .o_bul_y      (o_bul_y),
    .i_bul_ready  (i_bul_ready),
    .o_frame_done (o_frame_done),
    .o_fire_drop  (o_fire_drop),
    .o_overrun    (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            fire;
    logic            dir;
    logic [9:0]      px;
    logic            squat;
    logic [3:0]      n;
    logic            drop;
    logic [3:0][9:0] xs;
    logic [3:0][8:0] ys;
  } vec_t;

  vec_t tv [6];

  int n_checks = 0;
  int n_errors = 0;
  int got_n, got_drop, got_ovr, got_done, got_cyc;
  int got_x [8];
  int got_y [8];

  function automatic vec_t mk(input int fire, input int dir, input int px, input int sq,
                              input int n, input int drop,
                              input int x0, input int x1, input int x2, input int x3,
                              input int y0, input int y1, input int y2, input int y3);
    vec_t v;
    v.fire  = 1'(fire);
    v.dir   = 1'(dir);
    v.px    = 10'(px);
    v.squat = 1'(sq);
    v.n     = 4'(n);
    v.drop  = 1'(drop);
    v.xs[0] = 10'(x0); v.xs[1] = 10'(x1); v.xs[2] = 10'(x2); v.xs[3] = 10'(x3);
    v.ys[0] = 9'(y0);  v.ys[1] = 9'(y1);  v.ys[2] = 9'(y2);  v.ys[3] = 9'(y3);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " valid"}, int'(o_bul_valid), 0);
    check({tag, " x"}, int'(o_bul_x), 0);
    check({tag, " y"}, int'(o_bul_y), 0);
    check({tag, " done"}, int'(o_frame_done), 0);
    check({tag, " drop"}, int'(o_fire_drop), 0);
    check({tag, " overrun"}, int'(o_overrun), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_frame_tick = 1'b0;
    i_fire = 1'b0;
    i_fire_dir = 1'b0;
    i_player_x = '0;
    i_squat = 1'b0;
    i_bul_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic fire(input logic dir, input int px, input logic sq);
    @(negedge clk);
    i_fire_dir = dir;
    i_player_x = 10'(px);
    i_squat = sq;
    i_fire = 1'b1;
    @(negedge clk);
    i_fire = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_got();
    got_n = 0; got_drop = 0; got_ovr = 0; got_done = 0; got_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      got_x[i] = -1;
      got_y[i] = -1;
    end
  endtask

  // Starts on a negedge; cyc counts rising edges since the tick was sampled.
  task automatic collect(input int start_cyc);
    int cyc;
    cyc = start_cyc;
    while (got_done == 0 && cyc < 100) begin
      if (o_bul_valid && i_bul_ready && got_n < 8) begin
        got_x[got_n] = int'(o_bul_x);
        got_y[got_n] = int'(o_bul_y);
        got_n++;
      end
      if (o_fire_drop) got_drop++;
      if (o_overrun) got_ovr++;
      if (o_frame_done) begin
        got_done = 1;
        got_cyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic run_frame();
    clear_got();
    @(negedge clk);
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
    collect(1);
  endtask

  task automatic wait_valid(input string tag);
    int c;
    c = 0;
    while (!o_bul_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check({tag, " valid seen"}, int'(o_bul_valid), 1);
  endtask

  int hx, hy, unstable, ovr_cnt, done_cnt;

  initial begin
    rst = 1'b1;
    i_frame_tick = 1'b0;
    i_fire = 1'b0;
    i_fire_dir = 1'b0;
    i_player_x = '0;
    i_squat = 1'b0;
    i_bul_ready = 1'b1;

    //                 fire dir px  sq  n drop  x0   x1   x2   x3   y0   y1   y2   y3
    tv[0] = mk(1, 1, 100, 0, 1, 0, 100,   0,   0,   0, YST,   0,   0,   0);
    tv[1] = mk(1, 1, 200, 1, 2, 0, 108, 200,   0,   0, YST, YSQ,   0,   0);
    tv[2] = mk(1, 0, 300, 0, 3, 0, 116, 208, 300,   0, YST, YSQ, YST,   0);
    tv[3] = mk(1, 0, 400, 1, 4, 0, 124, 216, 292, 400, YST, YSQ, YST, YSQ);
    tv[4] = mk(1, 1, 500, 0, 4, 1, 132, 224, 284, 392, YST, YSQ, YST, YSQ);
    tv[5] = mk(0, 0,   0, 0, 4, 0, 140, 232, 276, 384, YST, YSQ, YST, YSQ);

    do_reset();

    for (int k = 0; k < 6; k++) begin
      if (tv[k].fire) fire(tv[k].dir, int'(tv[k].px), tv[k].squat);
      run_frame();
      check($sformatf("v%0d done", k), got_done, 1);
      check($sformatf("v%0d count", k), got_n, int'(tv[k].n));
      check($sformatf("v%0d latency", k), got_cyc, NB + int'(tv[k].n) + 2);
      check($sformatf("v%0d drop", k), got_drop, int'(tv[k].drop));
      check($sformatf("v%0d overrun", k), got_ovr, 0);
      for (int r = 0; r < int'(tv[k].n); r++) begin
        check($sformatf("v%0d rec%0d x", k, r), got_x[r], int'(tv[k].xs[r]));
        check($sformatf("v%0d rec%0d y", k, r), got_y[r], int'(tv[k].ys[r]));
      end
    end

    // Left shot near the left edge: removed, or wrapped to 5+1024-8.
    do_reset();
    fire(1'b0, 5, 1'b0);
    run_frame();
    check("left f1 count", got_n, 1);
    check("left f1 x", got_x[0], 5);
    check("left f1 y", got_y[0], YST);
    run_frame();
    check("left f2 done", got_done, 1);
    check("left f2 count", got_n, WRAP ? 1 : 0);
    check("left f2 latency", got_cyc, WRAP ? NB + 3 : NB + 2);
    if (WRAP) check("left f2 x", got_x[0], 1021);

    // Right edge: 1015+8 = 1023 stays, 1023+8 > 1023 leaves (or wraps to 7).
    do_reset();
    fire(1'b1, 1015, 1'b0);
    run_frame();
    check("right f1 x", got_x[0], 1015);
    run_frame();
    check("right f2 count", got_n, 1);
    check("right f2 x", got_x[0], 1023);
    run_frame();
    check("right f3 done", got_done, 1);
    check("right f3 count", got_n, WRAP ? 1 : 0);
    if (WRAP) check("right f3 x", got_x[0], 7);

    // Back-pressure: records hold while stalled, a tick during the stall overruns.
    do_reset();
    fire(1'b1, 10, 1'b0);
    run_frame();
    check("stall pre x", got_x[0], 10);
    fire(1'b0, 20, 1'b1);
    i_bul_ready = 1'b0;
    @(negedge clk);
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
    wait_valid("stall");
    hx = int'(o_bul_x);
    hy = int'(o_bul_y);
    check("stall first x", hx, 18);
    check("stall first y", hy, YST);
    unstable = 0;
    ovr_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) i_frame_tick = 1'b1;
      @(negedge clk);
      i_frame_tick = 1'b0;
      if (!o_bul_valid || int'(o_bul_x) != hx || int'(o_bul_y) != hy) unstable++;
      if (o_overrun) ovr_cnt++;
    end
    check("stall unstable cycles", unstable, 0);
    check("stall overrun pulses", ovr_cnt, 1);
    clear_got();
    i_bul_ready = 1'b1;
    collect(0);
    check("stall done", got_done, 1);
    check("stall count", got_n, 2);
    check("stall rec0 x", got_x[0], 18);
    check("stall rec1 x", got_x[1], 20);
    check("stall rec1 y", got_y[1], YSQ);

    // Reset in the middle of a stream.
    do_reset();
    fire(1'b1, 600, 1'b1);
    i_bul_ready = 1'b0;
    @(negedge clk);
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
    wait_valid("midrst");
    check("midrst x", int'(o_bul_x), 600);
    check("midrst y", int'(o_bul_y), YSQ);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    i_bul_ready = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_frame_done) done_cnt++;
    end
    check("midrst stray done", done_cnt, 0);
    run_frame();
    check("midrst next done", got_done, 1);
    check("midrst next count", got_n, 0);
    check("midrst next latency", got_cyc, NB + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
